// File: rtl/synth_pkg.sv
// synth_pkg: shared sample types, I2S frame geometry and tone-to-PCM scaling
package synth_pkg;
  typedef logic signed [31:0] tone_t;
  typedef logic signed [15:0] pcm_t;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS = 32;
  localparam int PCM_BITS = 16;
  function automatic pcm_t sat_shift(tone_t t, int sh);
    tone_t s;
    s = t >>> sh;
    return s > 32'sd32767 ? 16'sh7fff : s < -32'sd32768 ? 16'sh8000 : pcm_t'(s[15:0]);
  endfunction
endpackage

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: per-frame sample handshake between the voice FSM (master) and the I2S transmitter (slave)
interface audio_i2s_tx_if;
  import synth_pkg::*;
  tone_t SAMPLE_IN;
  logic SAMPLE_VALID;
  logic SAMPLE_REQ;
  modport master(output SAMPLE_IN, output SAMPLE_VALID, input SAMPLE_REQ);
  modport slave(input SAMPLE_IN, input SAMPLE_VALID, output SAMPLE_REQ);
endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK/LRCLK master timing with falling-edge and frame-start strobes
module i2s_clkgen
  import synth_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  output logic       AUD_BCLK,
  output logic       AUD_DACLRCK,
  output logic       fall,
  output logic       frame,
  output logic [4:0] k
);
  localparam int DW = BCLK_DIV > 2 ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic tc;
  // strobes describe the edge being taken this cycle, so bit_nxt is the post-edge count
  always_comb begin
    tc = div_cnt == DW'(BCLK_DIV - 1);
    fall = ENABLE && tc && AUD_BCLK;
    bit_nxt = bit_cnt + BW'(1);
    frame = fall && bit_nxt == '0;
    k = bit_nxt[4:0];
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N || !ENABLE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      AUD_BCLK <= 1'b0;
      AUD_DACLRCK <= 1'b0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DW'(1);
      if (tc) AUD_BCLK <= ~AUD_BCLK;
      if (fall) bit_cnt <= bit_nxt;
      if (fall) AUD_DACLRCK <= bit_nxt[BW-1];
    end
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: scales the summed tone to 16-bit PCM, double-buffers it and sends it mono on both I2S slots
module audio_i2s_tx
  import synth_pkg::*;
#(
  parameter int BCLK_DIV = 8,
  parameter int SHIFT = 15
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           ENABLE,
  input  logic           UNDERRUN_CLR,
  audio_i2s_tx_if.slave  smp,
  output logic           UNDERRUN,
  output logic           AUD_BCLK,
  output logic           AUD_DACLRCK,
  output logic           AUD_DACDAT
);
  pcm_t scaled, hold, shreg;
  logic fresh, fall, frame, dat_nxt, req;
  logic [4:0] k;
  logic [3:0] idx;
  i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .ENABLE(ENABLE),
    .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .fall(fall),
    .frame(frame),
    .k(k)
  );
  // slot bit k carries shreg[16-k]; bit 0 is the one-BCLK I2S delay, bits past the PCM word pad with 0
  always_comb begin
    scaled = sat_shift(smp.SAMPLE_IN, SHIFT);
    idx = 4'(5'd16 - k);
    dat_nxt = k != 5'd0 && k <= 5'(PCM_BITS) && shreg[idx];
  end
  assign smp.SAMPLE_REQ = req;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      hold <= '0;
      shreg <= '0;
      fresh <= 1'b0;
      req <= 1'b0;
      UNDERRUN <= 1'b0;
      AUD_DACDAT <= 1'b0;
    end else begin
      if (smp.SAMPLE_VALID) hold <= scaled;
      if (frame) shreg <= smp.SAMPLE_VALID ? scaled : hold;
      fresh <= !frame && (fresh || smp.SAMPLE_VALID);
      req <= frame;
      UNDERRUN <= (frame && !fresh && !smp.SAMPLE_VALID) || (UNDERRUN && !UNDERRUN_CLR);
      AUD_DACDAT <= !ENABLE ? 1'b0 : fall ? dat_nxt : AUD_DACDAT;
    end
endmodule
